// File: rtl/pmc_hw_accelerator_shift_ctrl_if.sv
// Handshake bundle between the PMC accelerator port and its shift sequencer.
// The slave side is the sequencer. The master side issues requests and watches progress.
interface pmc_hw_accelerator_shift_ctrl_if #(
    parameter int CNT_W = 4
) ();
    logic             start;
    logic             abort;
    logic             stall;
    logic             sh_a;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] beat_cnt;
    logic             err;

    modport master (
        output start, abort, stall,
        input  sh_a, busy, done, beat_cnt, err
    );

    modport slave (
        input  start, abort, stall,
        output sh_a, busy, done, beat_cnt, err
    );
endinterface

// File: rtl/pmc_hw_accelerator_shift_ctrl.sv
// Shift sequencer that moves one accelerator frame of BEATS 64-bit beats under a flop-driven sh_a.
// Optional stall timeout: define PMC_HW_ACC_SHIFT_TIMEOUT_EN.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; sh_a low
//   ST_SHIFT | frame in progress; sh_a follows !stall, one beat per sh_a-high edge
//   ST_DONE  | single completion cycle with done high
module pmc_hw_accelerator_shift_ctrl #(
    parameter int BEATS   = 8,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    pmc_hw_accelerator_shift_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((2 ** CNT_W) <= BEATS || TIMEOUT < 1) begin : g_param_check
        $error("pmc_hw_accelerator_shift_ctrl: CNT_W too small for BEATS or TIMEOUT < 1");
    end

    state_t           state;
    logic             sh_a_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] beat_cnt_q;

`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
    localparam int             TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    logic             err_q;
    logic [TMR_W-1:0] stall_tmr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sh_a_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            beat_cnt_q <= '0;
`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
            err_q      <= 1'b0;
            stall_tmr  <= TMR_LOAD;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state      <= ST_IDLE;
                sh_a_q     <= 1'b0;
                busy_q     <= 1'b0;
                beat_cnt_q <= '0;
`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
                err_q      <= 1'b0;
                stall_tmr  <= TMR_LOAD;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        sh_a_q <= 1'b0;
`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
                        stall_tmr <= TMR_LOAD;
`endif
                        if (bus.start) begin
                            state      <= ST_SHIFT;
                            busy_q     <= 1'b1;
                            sh_a_q     <= ~bus.stall;
                            beat_cnt_q <= '0;
`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
                            err_q      <= 1'b0;
`endif
                        end
                    end

                    ST_SHIFT: begin
                        if (sh_a_q) begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
                        if (!bus.stall) begin
                            stall_tmr <= TMR_LOAD;
                        end else if (stall_tmr != '0) begin
                            stall_tmr <= stall_tmr - 1'b1;
                        end
`endif
                        // Completion wins over a timeout landing on the same edge.
                        if (sh_a_q && beat_cnt_q == LAST_BEAT) begin
                            state  <= ST_DONE;
                            sh_a_q <= 1'b0;
                            done_q <= 1'b1;
`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
                        end else if (bus.stall && stall_tmr == '0) begin
                            state  <= ST_IDLE;
                            sh_a_q <= 1'b0;
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
`endif
                        end else begin
                            sh_a_q <= ~bus.stall;
                        end
                    end

                    ST_DONE: begin
                        state  <= ST_IDLE;
                        sh_a_q <= 1'b0;
                        busy_q <= 1'b0;
                    end

                    default: begin
                        state  <= ST_IDLE;
                        sh_a_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sh_a     = sh_a_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.beat_cnt = beat_cnt_q;
`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_pmc_hw_accelerator_shift_ctrl.sv
// Bench for the accelerator shift sequencer: directed frames plus random start/abort/stall traffic
// checked every cycle against a frame-level reference model.
module tb_pmc_hw_accelerator_shift_ctrl;
    localparam int BEATS   = 8;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pmc_hw_accelerator_shift_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pmc_hw_accelerator_shift_ctrl #(
        .BEATS   (BEATS),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: a frame owes BEATS beats; every cycle with the enable
    // predicted high pays one. A stalled edge withholds the enable for the next cycle.
    bit m_busy, m_en, m_done, m_tail, m_err;
    int m_owed, m_cnt, m_srun;

    function automatic void model_reset();
        m_busy = 0; m_en = 0; m_done = 0; m_tail = 0; m_err = 0;
        m_owed = 0; m_cnt = 0; m_srun = 0;
    endfunction

    function automatic void model_edge(bit s, bit a, bit st);
        m_done = 0;
        if (a) begin
            m_busy = 0; m_en = 0; m_cnt = 0; m_err = 0; m_owed = 0; m_tail = 0;
            return;
        end
        if (m_tail) begin
            m_tail = 0; m_busy = 0;
            return;
        end
        if (!m_busy) begin
            if (s) begin
                m_busy = 1; m_owed = BEATS; m_cnt = 0; m_en = !st; m_srun = 0; m_err = 0;
            end
            return;
        end
        if (m_en) begin
            m_owed--;
            m_cnt++;
        end
        if (m_owed == 0) begin
            m_en = 0; m_done = 1; m_tail = 1;
            return;
        end
        m_srun = st ? m_srun + 1 : 0;
        if (TO_EN && m_srun == TIMEOUT) begin
            m_busy = 0; m_en = 0; m_err = 1;
            return;
        end
        m_en = !st;
    endfunction

    int cyc = 0;
    int sh_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int t0;

    task automatic cycle(input bit s, input bit a, input bit st);
        bus.start = s;
        bus.abort = a;
        bus.stall = st;
        @(posedge clk);
        model_edge(s, a, st);
        #1;
        cyc++;
        if (bus.sh_a === 1'b1) sh_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        check("sh_a",     32'(bus.sh_a),     32'(m_en));
        check("busy",     32'(bus.busy),     32'(m_busy));
        check("done",     32'(bus.done),     32'(m_done));
        check("beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
        check("err",      32'(bus.err),      32'(m_err));
    endtask

    task automatic clear_stats();
        sh_cnt = 0; done_cnt = 0; done_cyc = -1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.stall = 1'b0;
        model_reset();

        #12;
        check("rst_sh_a", 32'(bus.sh_a), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_beat_cnt", 32'(bus.beat_cnt), 0);
        check("rst_err", 32'(bus.err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic frame
        repeat (2) cycle(0, 0, 0);
        clear_stats();
        cycle(1, 0, 0); t0 = cyc;
        repeat (10) cycle(0, 0, 0);
        check("basic_sh_a_cycles", sh_cnt, BEATS);
        check("basic_done_count", done_cnt, 1);
        check("basic_done_delay", done_cyc - t0, BEATS);
        check("basic_beat_hold", 32'(bus.beat_cnt), BEATS);
        check("basic_busy_after", 32'(bus.busy), 0);

        // stall for three edges after beat 3
        clear_stats();
        cycle(1, 0, 0); t0 = cyc;
        repeat (2) cycle(0, 0, 0);
        repeat (3) cycle(0, 0, 1);
        repeat (10) cycle(0, 0, 0);
        check("stall_sh_a_cycles", sh_cnt, BEATS);
        check("stall_done_count", done_cnt, 1);
        check("stall_done_delay", done_cyc - t0, BEATS + 3);

        // abort after 4 beats
        clear_stats();
        cycle(1, 0, 0);
        repeat (4) cycle(0, 0, 0);
        check("abort_pre_cnt", 32'(bus.beat_cnt), 4);
        cycle(0, 1, 0);
        check("abort_sh_a", 32'(bus.sh_a), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_beat_cnt", 32'(bus.beat_cnt), 0);
        repeat (3) cycle(0, 0, 0);
        check("abort_no_done", done_cnt, 0);
        clear_stats();
        cycle(1, 0, 0); t0 = cyc;
        repeat (10) cycle(0, 0, 0);
        check("abort_refr_sh_a", sh_cnt, BEATS);
        check("abort_refr_done", done_cyc - t0, BEATS);

        // start pulsed during SHIFT and during the DONE cycle
        clear_stats();
        cycle(1, 0, 0);
        repeat (2) cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (5) cycle(0, 0, 0);
        check("ign_done_now", 32'(bus.done), 1);
        cycle(1, 0, 0);
        repeat (12) cycle(0, 0, 0);
        check("ign_done_count", done_cnt, 1);
        check("ign_sh_a_cycles", sh_cnt, BEATS);
        check("ign_busy_after", 32'(bus.busy), 0);

        // asynchronous reset mid-frame
        clear_stats();
        cycle(1, 0, 0);
        repeat (4) cycle(0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_sh_a", 32'(bus.sh_a), 0);
        check("mrst_busy", 32'(bus.busy), 0);
        check("mrst_done", 32'(bus.done), 0);
        check("mrst_beat_cnt", 32'(bus.beat_cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
        repeat (6) cycle(0, 0, 0);
        check("mrst_stays_idle", sh_cnt + done_cnt, 0);

`ifdef PMC_HW_ACC_SHIFT_TIMEOUT_EN
        // stall timeout
        clear_stats();
        cycle(1, 0, 1);
        repeat (3) cycle(0, 0, 1);
        check("to_busy_before", 32'(bus.busy), 1);
        cycle(0, 0, 1);
        check("to_busy", 32'(bus.busy), 0);
        check("to_err", 32'(bus.err), 1);
        repeat (2) cycle(0, 0, 0);
        check("to_err_sticky", 32'(bus.err), 1);
        check("to_no_done", done_cnt, 0);
        cycle(1, 0, 0);
        check("to_err_clear", 32'(bus.err), 0);
        repeat (10) cycle(0, 0, 0);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 30);
        end
        repeat (15) cycle(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
